// File: rtl/stb_drain_ctrl_if.sv
// stb_drain_ctrl_if: data-cache request/response port shared by the drain controller and the D-cache
// master: controller side (drives req_*, receives req_ready and resp_*)
// slave: cache side (receives req_*, drives req_ready and resp_*)
interface stb_drain_ctrl_if #(
    parameter int PA_WIDTH = 32,
    parameter int N_BYTES  = 8,
    parameter int BYTE_W   = 8
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [PA_WIDTH-1:0]         req_addr;
    logic [N_BYTES*BYTE_W-1:0]   req_wdata;
    logic [N_BYTES-1:0]          req_be;
    logic                        resp_valid;
    logic                        resp_ok;
    logic [N_BYTES*BYTE_W-1:0]   resp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_ok, resp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_ok, resp_rdata
    );
endinterface

// File: rtl/stb_drain_ctrl.sv
// stb_drain_ctrl: arbitrates the single D-cache port between pipeline loads and store-buffer commits
// clk, rst           : clock, asynchronous active-high reset
// i_ld_* / o_ld_*    : load request, acceptance and load response toward the memory stage
// i_stb_* / o_stb_pop: oldest store-buffer line, occupancy, and retire pulse
// i_fence / o_fence_done: fence request and drained acknowledge
// c                  : D-cache request/response port (master side)
module stb_drain_ctrl #(
    parameter int PA_WIDTH   = 32,
    parameter int N_BYTES    = 8,
    parameter int BYTE_W     = 8,
    parameter int N_LINES    = 4,
    parameter int HIGH_WM    = 3,
    parameter int MAX_STARVE = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_ld_valid,
    input  logic [PA_WIDTH-1:0]               i_ld_addr,
    output logic                              o_ld_ready,
    output logic                              o_ld_resp_valid,
    output logic                              o_ld_resp_ok,
    output logic [N_BYTES*BYTE_W-1:0]         o_ld_resp_data,
    input  logic                              i_stb_valid,
    input  logic [PA_WIDTH-1:0]               i_stb_addr,
    input  logic [N_BYTES*BYTE_W-1:0]         i_stb_data,
    input  logic [N_BYTES-1:0]                i_stb_be,
    input  logic [$clog2(N_LINES+1)-1:0]      i_stb_count,
    output logic                              o_stb_pop,
    input  logic                              i_fence,
    output logic                              o_fence_done,
    stb_drain_ctrl_if.master                  c
);
    localparam int CW = $clog2(N_LINES+1);
    localparam int SW = $clog2(MAX_STARVE+1);
    localparam int DW = N_BYTES*BYTE_W;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t              state, state_nx;
    logic                is_st, fence_pending;
    logic [SW-1:0]       starve_cnt;
    logic [PA_WIDTH-1:0] addr_q;
    logic [DW-1:0]       wdata_q;
    logic [N_BYTES-1:0]  be_q;
    logic                idle, store_prio, st_win, ld_win, st_grant, ld_grant, fence_ok, resp;
    assign idle       = state == IDLE;
    assign store_prio = fence_pending | (i_stb_count >= CW'(HIGH_WM)) | (starve_cnt >= SW'(MAX_STARVE));
    assign st_win     = i_stb_valid & (store_prio | !i_ld_valid);
    assign ld_win     = i_ld_valid & !fence_pending & !st_win;
    assign st_grant   = idle & st_win;
    assign ld_grant   = idle & ld_win;
    assign fence_ok   = fence_pending & idle & !i_stb_valid & (i_stb_count == '0);
    assign resp       = (state == WAIT) & c.resp_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = idle ? ((st_win | ld_win) ? REQ : IDLE)
                 : state == REQ ? (c.req_ready ? WAIT : REQ)
                 : (c.resp_valid ? IDLE : WAIT);
    end
    // Combinational grant/done are masked by rst so every output is zero the moment reset asserts.
    always_comb begin
        o_ld_ready      = !rst & ld_grant;
        o_fence_done    = !rst & fence_ok;
        c.req_valid     = state == REQ;
        c.req_we        = is_st;
        c.req_addr      = addr_q;
        c.req_wdata     = wdata_q;
        c.req_be        = be_q;
        o_ld_resp_valid = resp & !is_st;
        o_ld_resp_ok    = resp & !is_st & c.resp_ok;
        o_ld_resp_data  = (resp & !is_st) ? c.resp_rdata : '0;
        o_stb_pop       = resp & is_st & c.resp_ok;
    end
    // A failed store leaves the line in the STB; it simply wins again later, so starve_cnt is untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_st         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            fence_pending <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            if (st_grant | ld_grant) begin
                is_st   <= st_grant;
                addr_q  <= st_grant ? i_stb_addr : i_ld_addr;
                wdata_q <= st_grant ? i_stb_data : '0;
                be_q    <= st_grant ? i_stb_be : '0;
            end
            fence_pending <= i_fence | (fence_pending & !fence_ok);
            starve_cnt    <= st_grant ? '0
                           : (ld_grant & i_stb_valid & (starve_cnt < SW'(MAX_STARVE))) ? starve_cnt + 1'b1
                           : starve_cnt;
        end
    end
`ifndef SYNTHESIS
    a_stb_count: assert property (@(posedge clk) disable iff (rst) !(i_stb_valid && i_stb_count == '0));
    a_resp_wait: assert property (@(posedge clk) disable iff (rst) c.resp_valid |-> state == WAIT);
`endif
endmodule

// File: tb/tb_stb_drain_ctrl.sv
// tb_stb_drain_ctrl: randomized scoreboard bench for stb_drain_ctrl with a transaction-level reference model
module tb_stb_drain_ctrl;
    localparam int PA = 32, NB = 8, BW = 8, DW = 64, NL = 4, HWM = 3, MS = 8;
    typedef struct packed {logic we; logic [31:0] addr; logic [63:0] wdata; logic [7:0] be;} req_t;
    typedef struct packed {logic ld; logic ok; logic [63:0] data; logic pop;} resp_t;
    typedef struct packed {logic r; logic f;} cyc_t;
    typedef struct packed {logic [31:0] addr; logic [63:0] data; logic [7:0] be;} line_t;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic ld_valid = 0, ld_ready, ld_resp_valid, ld_resp_ok, stb_valid = 0, stb_pop, fence = 0, fence_done;
    logic [31:0] ld_addr = 0, stb_addr = 0;
    logic [63:0] ld_resp_data, stb_data = 0;
    logic [7:0]  stb_be = 0;
    logic [2:0]  stb_count = 0;
    stb_drain_ctrl_if #(.PA_WIDTH(PA), .N_BYTES(NB), .BYTE_W(BW)) c();
    stb_drain_ctrl #(.PA_WIDTH(PA), .N_BYTES(NB), .BYTE_W(BW), .N_LINES(NL), .HIGH_WM(HWM), .MAX_STARVE(MS)) dut (
        .clk(clk), .rst(rst),
        .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .o_ld_ready(ld_ready),
        .o_ld_resp_valid(ld_resp_valid), .o_ld_resp_ok(ld_resp_ok), .o_ld_resp_data(ld_resp_data),
        .i_stb_valid(stb_valid), .i_stb_addr(stb_addr), .i_stb_data(stb_data), .i_stb_be(stb_be),
        .i_stb_count(stb_count), .o_stb_pop(stb_pop),
        .i_fence(fence), .o_fence_done(fence_done),
        .c(c)
    );
    cyc_t  q_cyc[$];
    req_t  q_req[$];
    resp_t q_resp[$];
    line_t stb_q[$];
    int total = 0, bad = 0;
    bit busy, m_st, fpend, m_ld_acc, m_pop, c_acc, pend;
    int starve, dly;
    cyc_t mon_e; req_t mon_r; resp_t mon_p;
    task automatic chk(string n, logic [255:0] a, logic [255:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic fail_now(string n);
        total++;
        bad++;
        $display("FAIL %s at %0t", n, $time);
    endtask
    function automatic logic [255:0] all_outs();
        return {ld_ready, ld_resp_valid, ld_resp_ok, ld_resp_data, stb_pop, fence_done,
                c.req_valid, c.req_we, c.req_addr, c.req_wdata, c.req_be};
    endfunction
    task automatic drive_stb();
        stb_valid = stb_q.size() > 0;
        stb_count = 3'(stb_q.size());
        stb_addr  = stb_valid ? stb_q[0].addr : '0;
        stb_data  = stb_valid ? stb_q[0].data : '0;
        stb_be    = stb_valid ? stb_q[0].be : '0;
    endtask
    // Reference: one transaction at a time; who gets the port follows the priority rules directly.
    task automatic model_step();
        bit prio, stw, ldw, fd;
        prio = fpend || stb_count >= HWM || starve >= MS;
        stw  = stb_valid && (prio || !ld_valid);
        ldw  = ld_valid && !fpend && !stw;
        fd   = fpend && !busy && !stb_valid && stb_count == 0;
        q_cyc.push_back('{r: !busy && ldw, f: fd});
        m_ld_acc = !busy && ldw;
        m_pop    = 0;
        c_acc    = c.req_valid && c.req_ready;
        if (c.resp_valid) begin
            q_resp.push_back('{ld: !m_st, ok: c.resp_ok, data: c.resp_rdata, pop: m_st && c.resp_ok});
            m_pop = m_st && c.resp_ok;
            busy  = 0;
        end else if (!busy && stw) begin
            q_req.push_back('{we: 1'b1, addr: stb_addr, wdata: stb_data, be: stb_be});
            busy = 1; m_st = 1; starve = 0;
        end else if (!busy && ldw) begin
            q_req.push_back('{we: 1'b0, addr: ld_addr, wdata: 64'h0, be: 8'h0});
            busy = 1; m_st = 0;
            if (stb_valid && starve < MS) starve++;
        end
        fpend = fence || (fpend && !fd);
    endtask
    task automatic env_step(int ldr, int stbr, int fr);
        line_t l;
        if (m_pop) void'(stb_q.pop_front());
        if (stb_q.size() < NL && $urandom_range(99) < stbr) begin
            l.addr = $urandom;
            l.addr[2:0] = 3'b0;
            l.data = {$urandom, $urandom};
            l.be = 8'($urandom);
            stb_q.push_back(l);
        end
        drive_stb();
        if (m_ld_acc || !ld_valid) begin
            ld_valid = $urandom_range(99) < ldr;
            ld_addr  = $urandom;
        end
        fence = $urandom_range(999) < fr;
        c.resp_valid = 0; c.resp_ok = 0; c.resp_rdata = '0;
        if (c_acc) begin pend = 1; dly = $urandom_range(0, 2); end
        if (pend) begin
            if (dly == 0) begin
                c.resp_valid = 1;
                c.resp_ok    = $urandom_range(3) != 0;
                c.resp_rdata = {$urandom, $urandom};
                pend = 0;
            end else dly--;
        end
        c.req_ready = 1'($urandom_range(1));
    endtask
    task automatic run(int n, int ldr, int stbr, int fr);
        repeat (n) begin
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
            env_step(ldr, stbr, fr);
        end
    endtask
    task automatic reset_model();
        busy = 0; m_st = 0; fpend = 0; starve = 0; m_ld_acc = 0; m_pop = 0; c_acc = 0; pend = 0; dly = 0;
        q_cyc.delete(); q_req.delete(); q_resp.delete();
    endtask
    task automatic mid_reset();
        int k = 0;
        bit hit = 0;
        while (!hit && k < 300) begin
            @(negedge clk);
            model_step();
            if (c.req_valid) hit = 1;
            else begin
                @(posedge clk);
                #1;
                env_step(60, 30, 5);
                k++;
            end
        end
        if (!hit) fail_now("mid_reset_no_req");
        #1;
        rst = 1;
        ld_valid = 1;
        c.resp_valid = 0; c.req_ready = 0;
        reset_model();
        #1;
        chk("mid_reset_req_valid", c.req_valid, 0);
        chk("mid_reset_outputs", all_outs(), 0);
        @(posedge clk);
        #1;
        chk("mid_reset_hold", all_outs(), 0);
        @(posedge clk);
        #1;
        stb_q.delete();
        stb_q.push_back('{addr: 32'h0000_2000, data: 64'h1122_3344_5566_7788, be: 8'hF0});
        drive_stb();
        ld_valid = 0; fence = 0;
        rst = 0;
    endtask
    task automatic drain();
        int k = 0;
        while ((busy || stb_q.size() > 0 || fpend) && k < 600) begin
            run(1, 0, 0, 0);
            k++;
        end
        if (busy || stb_q.size() > 0 || fpend) fail_now("drain_timeout");
        chk("leftover_expected", q_req.size() + q_resp.size(), 0);
    endtask
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (q_cyc.size() == 0) fail_now("cycle_expectation_missing");
            else begin
                mon_e = q_cyc.pop_front();
                chk("ld_ready", ld_ready, mon_e.r);
                chk("fence_done", fence_done, mon_e.f);
            end
            if (c.req_valid && c.req_ready) begin
                if (q_req.size() == 0) fail_now("unexpected_cache_req");
                else begin
                    mon_r = q_req.pop_front();
                    chk("cache_req", {c.req_we, c.req_addr, c.req_wdata, c.req_be}, mon_r);
                end
            end
            if (ld_resp_valid || stb_pop || c.resp_valid) begin
                if (q_resp.size() == 0) fail_now("unexpected_response");
                else begin
                    mon_p = q_resp.pop_front();
                    chk("ld_resp_valid", ld_resp_valid, mon_p.ld);
                    if (mon_p.ld) begin
                        chk("ld_resp_ok", ld_resp_ok, mon_p.ok);
                        chk("ld_resp_data", ld_resp_data, mon_p.data);
                    end
                    chk("stb_pop", stb_pop, mon_p.pop);
                end
            end
        end
    end
    initial begin
        c.req_ready = 0; c.resp_valid = 0; c.resp_ok = 0; c.resp_rdata = '0;
        reset_model();
        #2;
        ld_valid = 1; ld_addr = 32'h100;
        stb_valid = 1; stb_count = 1; stb_addr = 32'h40; stb_be = 8'hFF;
        #1;
        chk("reset_outputs", all_outs(), 0);
        @(posedge clk);
        #2;
        chk("reset_outputs_after_edge", all_outs(), 0);
        @(posedge clk);
        #1;
        stb_q.delete();
        drive_stb();
        ld_valid = 0;
        rst = 0;
        run(300, 90, 10, 0);
        run(300, 50, 40, 0);
        run(400, 60, 30, 20);
        mid_reset();
        run(20, 0, 0, 0);
        run(400, 60, 30, 20);
        drain();
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stb_drain_ctrl.md
Name: stb_drain_ctrl

Overview:
- Sequences the single data-cache port between pipeline loads and commits from the store buffer (STB).
- Picks one requester per transaction, issues a registered request, waits for the cache response, then pops the STB line on a successful store.
- Store priority is raised by STB occupancy or load starvation; a fence drains the STB completely before being acknowledged.
- Sits between the memory stage, the STB commit port and the D-cache request port.

Parameters:
PA_WIDTH, 32, physical address width
N_BYTES, 8, bytes per STB line / cache access (power of 2)
BYTE_W, 8, bits per byte lane
N_LINES, 4, STB depth (occupancy range 0..N_LINES)
HIGH_WM, 3, occupancy at or above which stores win arbitration
MAX_STARVE, 8, lost store arbitrations before stores are forced to win

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_ld_valid  in  1  pipeline load request
i_ld_addr  in  PA_WIDTH  load address
o_ld_ready  out  1  load accepted this cycle
o_ld_resp_valid  out  1  load response
o_ld_resp_ok  out  1  load hit / ok (0 = miss, pipeline replays)
o_ld_resp_data  out  N_BYTES*BYTE_W  load line data
i_stb_valid  in  1  oldest STB line valid
i_stb_addr  in  PA_WIDTH  oldest line address (offset bits zero)
i_stb_data  in  N_BYTES*BYTE_W  oldest line data
i_stb_be  in  N_BYTES  oldest line byte-valid mask
i_stb_count  in  $clog2(N_LINES+1)  STB occupancy
o_stb_pop  out  1  one-cycle pulse: oldest line committed, retire it
i_fence  in  1  one-cycle fence request
o_fence_done  out  1  one-cycle pulse: STB drained
o_c_req_valid  out  1  cache request valid
i_c_req_ready  in  1  cache accepts request
o_c_req_we  out  1  1 = store, 0 = load
o_c_req_addr  out  PA_WIDTH  request address
o_c_req_wdata  out  N_BYTES*BYTE_W  store data
o_c_req_be  out  N_BYTES  store byte enables (all-zero for loads)
i_c_resp_valid  in  1  cache response
i_c_resp_ok  in  1  hit / success
i_c_resp_rdata  in  N_BYTES*BYTE_W  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT. One transaction outstanding at a time. A type register records LD or ST.
- Arbitration, evaluated only in IDLE:
  - store_prio = fence_pending | (i_stb_count >= HIGH_WM) | (starve_cnt >= MAX_STARVE).
  - Store wins if i_stb_valid & (store_prio | !i_ld_valid).
  - Load wins if i_ld_valid & !fence_pending & !(store wins).
- o_ld_ready = IDLE & load wins (combinational). On the winning cycle, latch addr/data/be/we into request registers and go to REQ.
- REQ: o_c_req_valid=1 with stable fields until i_c_req_ready, then go to WAIT. REQ is entered no earlier than 1 cycle after the grant.
- WAIT: on i_c_resp_valid, return to IDLE.
  - LD: o_ld_resp_valid=1, o_ld_resp_ok=i_c_resp_ok, o_ld_resp_data=i_c_resp_rdata, all combinational in the same cycle.
  - ST: o_stb_pop = i_c_resp_ok. On !ok, no pop; the same line re-arbitrates from IDLE (retry). starve_cnt is not reset.
- starve_cnt: increments (saturating at MAX_STARVE) on each IDLE cycle with i_stb_valid where load wins; clears when a store is granted.
- Fence:
  - i_fence sets fence_pending; the set takes priority over clear in the same cycle.
  - While pending, no loads are accepted; an in-flight load completes normally.
  - o_fence_done pulses for 1 cycle when fence_pending & IDLE & !i_stb_valid & i_stb_count==0; pending clears that cycle. A fence with an empty STB completes in 1 cycle (the cycle after i_fence).
- Simultaneous events: i_stb_valid with i_stb_count==0 is illegal (assert). Any i_c_resp_valid outside WAIT is ignored (assert).
- Reset, async, at any time including mid-transaction:
  - State returns to IDLE; fence_pending=0, starve_cnt=0, request registers cleared.
  - All outputs 0 (o_ld_ready, o_ld_resp_*, o_stb_pop, o_fence_done, o_c_req_*).
  - The cache is reset concurrently, so no response is expected after reset.

Test Plan:
1. Load only: i_ld_valid, addr 0x100, ready at first REQ cycle, resp ok data 0xAB after 2 cycles -> o_ld_ready at t0, o_c_req_valid t1 with we=0/be=0, o_ld_resp_valid=1 ok=1 data 0xAB, no o_stb_pop.
2. Contention, count=1: load and store both valid -> load wins. starve_cnt increments each lost IDLE cycle; after 8 lost arbitrations the store wins despite i_ld_valid, then starve_cnt=0.
3. Watermark: count=3, both valid -> store issued first with we=1, be=i_stb_be. Resp ok -> exactly one o_stb_pop pulse.
4. Store miss retry: resp ok=0 -> no pop, state IDLE, same addr reissued; second resp ok=1 -> one pop.
5. Fence with 2 lines queued plus a pending load: load blocked (o_ld_ready=0); two stores commit, two pops; o_fence_done pulses once count=0; the next load is accepted the following cycle.
6. Reset asserted while in REQ with o_c_req_valid=1 -> all outputs 0 immediately; after release, a store with count=1 is issued from IDLE normally.
